wall_fleet_ctrl: RTL and testbench

- Parametrised controller for up to N_WALLS scrolling walls.
- Each wall runs its own READY/MOVE/STOP/DRAW state machine and steps left on a shared frame-rate divider.
- Walls share a single drawing engine through round-robin arbitration.
- Sits between game logic (launch requests, per-wall collision flags) and the VGA draw datapath.

---
 rtl/wall_pkg.sv | 23 ++
 rtl/wall_rr_arbiter.sv | 47 ++++
 rtl/wall_fleet_ctrl.sv | 207 ++++++++++++++++++++
 tb/tb_wall_fleet_ctrl.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/wall_pkg.sv
// Shared types for the wall fleet controller: per-wall state codes, draw job kinds,
// and an index-width helper.
package wall_pkg;

  typedef enum logic [3:0] {
    W_READY = 4'h5,
    W_MOVE  = 4'h6,
    W_STOP  = 4'h7,
    W_DRAW  = 4'h8
  } wall_state_e;

  typedef enum logic [1:0] {
    K_PLACE = 2'd0,
    K_SHIFT = 2'd1,
    K_ERASE = 2'd2
  } draw_kind_e;

  // Width of an index over n items, never less than one bit.
  function automatic int id_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/wall_rr_arbiter.sv
// Round-robin grant over N requesters with a registered priority pointer.
// The pointer parks on a stalled winner so the granted job stays put until accepted.
module wall_rr_arbiter #(
  parameter int N    = 4,
  parameter int ID_W = 2
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic [N-1:0]    req_i,
  input  logic            xfer_i,
  output logic            valid_o,
  output logic [ID_W-1:0] grant_o
);

  logic [ID_W-1:0] ptr_q, ptr_d;
  logic [ID_W-1:0] idx;

  // NOTE: every variable gets a default before the search loop so no latch is inferred.
  always_comb begin
    valid_o = 1'b0;
    grant_o = ptr_q;
    idx     = '0;
    for (int k = 0; k < N; k++) begin
      idx = ID_W'((int'(ptr_q) + k) % N);
      if (!valid_o && req_i[idx]) begin
        valid_o = 1'b1;
        grant_o = idx;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (valid_o) begin
      if (!xfer_i)                   ptr_d = grant_o;
      else if (int'(grant_o) == N-1) ptr_d = '0;
      else                           ptr_d = grant_o + 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (!resetn) ptr_q <= '0;
    else         ptr_q <= ptr_d;
  end

endmodule

// File: rtl/wall_fleet_ctrl.sv
// Fleet of scrolling walls sharing one draw engine. Define WALL_WRAP_EN to wrap walls
// back to X_START at the end of track; otherwise they are erased and retired.
module wall_fleet_ctrl
  import wall_pkg::*;
#(
  parameter int N_WALLS  = 4,
  parameter int X_W      = 8,
  parameter int X_START  = 159,
  parameter int X_END    = 0,
  parameter int STEP     = 1,
  parameter int MOVE_DIV = 2
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          frame_tick,
  input  logic                          launch,
  output logic                          launch_ack,
  input  logic [N_WALLS-1:0]            touched,
  output logic                          draw_valid,
  input  logic                          draw_ready,
  output logic [id_width(N_WALLS)-1:0]  draw_id,
  output logic [1:0]                    draw_kind,
  output logic [X_W-1:0]                draw_x,
  output logic [X_W-1:0]                draw_prev_x,
  output logic [4*N_WALLS-1:0]          wall_state,
  output logic [X_W*N_WALLS-1:0]        wall_x,
  output logic                          any_stopped
);

  localparam int              ID_W      = id_width(N_WALLS);
  localparam int              DIV_W     = id_width(MOVE_DIV);
  localparam logic [X_W-1:0]  X_START_C = X_W'(X_START);
  localparam logic [X_W-1:0]  STEP_C    = X_W'(STEP);
  localparam logic [X_W:0]    END_LIM   = (X_W+1)'(X_END + STEP);

  logic [DIV_W-1:0]   div_q, div_d;
  logic               move_pulse;
  logic               launch_ack_q;
  logic               xfer, found;
  logic [ID_W-1:0]    grant;
  logic [N_WALLS-1:0] ready_vec, stop_vec, req_vec, launch_sel;
  draw_kind_e         kind_w  [N_WALLS];
  logic [X_W-1:0]     jx_w    [N_WALLS];
  logic [X_W-1:0]     jp_w    [N_WALLS];

  always_comb begin
    move_pulse = frame_tick && (div_q == DIV_W'(MOVE_DIV - 1));
    div_d      = div_q;
    if (frame_tick) div_d = move_pulse ? '0 : div_q + 1'b1;
  end

  always_comb begin
    launch_sel = '0;
    found      = 1'b0;
    for (int i = 0; i < N_WALLS; i++) begin
      if (launch && ready_vec[i] && !found) begin
        launch_sel[i] = 1'b1;
        found         = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      div_q        <= '0;
      launch_ack_q <= 1'b0;
    end else begin
      div_q        <= div_d;
      launch_ack_q <= launch && (|ready_vec);
    end
  end

  wall_rr_arbiter #(.N(N_WALLS), .ID_W(ID_W)) u_arb (
    .clk     (clk),
    .resetn  (resetn),
    .req_i   (req_vec),
    .xfer_i  (xfer),
    .valid_o (draw_valid),
    .grant_o (grant)
  );

  assign xfer        = draw_valid && draw_ready;
  assign launch_ack  = launch_ack_q;
  assign any_stopped = |stop_vec;
  assign draw_id     = grant;
  assign draw_kind   = kind_w[grant];
  assign draw_x      = jx_w[grant];
  assign draw_prev_x = jp_w[grant];

  for (genvar i = 0; i < N_WALLS; i++) begin : g_wall
    wall_state_e    state_q, state_d, ret_q, ret_d;
    draw_kind_e     kind_q, kind_d;
    logic [X_W-1:0] x_q, x_d, jx_q, jx_d, jp_q, jp_d;
    logic           pend_q, pend_d, mv_q, mv_d, tp_q, tp_d;
    logic           own_xfer;

    assign own_xfer = xfer && (grant == ID_W'(i));

    always_comb begin
      state_d = state_q;
      ret_d   = ret_q;
      kind_d  = kind_q;
      x_d     = x_q;
      jx_d    = jx_q;
      jp_d    = jp_q;
      pend_d  = pend_q;
      mv_d    = mv_q;
      tp_d    = tp_q;
      case (state_q)
        W_READY: if (launch_sel[i]) begin
          x_d     = X_START_C;
          kind_d  = K_PLACE;
          jx_d    = X_START_C;
          jp_d    = X_START_C;
          pend_d  = 1'b1;
          mv_d    = 1'b0;
          tp_d    = 1'b0;
          ret_d   = W_MOVE;
          state_d = W_DRAW;
        end
        W_MOVE: begin
          if (touched[i] || tp_q) begin
            kind_d  = K_ERASE;
            jx_d    = x_q;
            jp_d    = x_q;
            pend_d  = 1'b1;
            ret_d   = W_STOP;
            state_d = W_DRAW;
          end else if (mv_q || move_pulse) begin
            mv_d    = 1'b0;
            pend_d  = 1'b1;
            state_d = W_DRAW;
            if ({1'b0, x_q} < END_LIM) begin
`ifdef WALL_WRAP_EN
              kind_d = K_SHIFT;
              x_d    = X_START_C;
              jx_d   = X_START_C;
              jp_d   = x_q;
              ret_d  = W_MOVE;
`else
              kind_d = K_ERASE;
              jx_d   = x_q;
              jp_d   = x_q;
              ret_d  = W_READY;
`endif
            end else begin
              kind_d = K_SHIFT;
              x_d    = x_q - STEP_C;
              jx_d   = x_q - STEP_C;
              jp_d   = x_q;
              ret_d  = W_MOVE;
            end
          end
        end
        W_DRAW: begin
          // Pulses and touches seen while drawing are held for the next MOVE cycle.
          mv_d = mv_q || move_pulse;
          tp_d = tp_q || touched[i];
          if (own_xfer) begin
            pend_d  = 1'b0;
            state_d = ret_q;
          end
        end
        W_STOP: begin
          mv_d    = 1'b0;
          tp_d    = 1'b0;
          state_d = W_READY;
        end
        default: state_d = W_READY;
      endcase
    end

    always_ff @(posedge clk) begin
      if (!resetn) begin
        state_q <= W_READY;
        ret_q   <= W_READY;
        kind_q  <= K_PLACE;
        x_q     <= X_START_C;
        jx_q    <= X_START_C;
        jp_q    <= X_START_C;
        pend_q  <= 1'b0;
        mv_q    <= 1'b0;
        tp_q    <= 1'b0;
      end else begin
        state_q <= state_d;
        ret_q   <= ret_d;
        kind_q  <= kind_d;
        x_q     <= x_d;
        jx_q    <= jx_d;
        jp_q    <= jp_d;
        pend_q  <= pend_d;
        mv_q    <= mv_d;
        tp_q    <= tp_d;
      end
    end

    assign wall_state[4*i +: 4]   = state_q;
    assign wall_x[X_W*i +: X_W]   = x_q;
    assign ready_vec[i]           = (state_q == W_READY);
    assign stop_vec[i]            = (state_q == W_STOP);
    assign req_vec[i]             = pend_q;
    assign kind_w[i]              = kind_q;
    assign jx_w[i]                = jx_q;
    assign jp_w[i]                = jp_q;
  end

endmodule

// File: tb/tb_wall_fleet_ctrl.sv
// Directed bench for wall_fleet_ctrl: a default 4-wall instance plus a 1-wall short-track
// instance for end-of-track behaviour (expectations follow WALL_WRAP_EN).
module tb_wall_fleet_ctrl;

  logic        clk = 1'b0;
  logic        resetn, frame_tick, launch, draw_ready;
  logic [3:0]  touched;
  logic        launch_ack, draw_valid, any_stopped;
  logic [1:0]  draw_id, draw_kind;
  logic [7:0]  draw_x, draw_prev_x;
  logic [15:0] wall_state;
  logic [31:0] wall_x;

  logic        frame_s, launch_s, ready_s;
  logic [0:0]  touched_s, draw_id_s;
  logic        launch_ack_s, draw_valid_s, any_stopped_s;
  logic [1:0]  draw_kind_s;
  logic [7:0]  draw_x_s, draw_prev_x_s, wall_x_s;
  logic [3:0]  wall_state_s;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  wall_fleet_ctrl dut (
    .clk(clk), .resetn(resetn), .frame_tick(frame_tick), .launch(launch),
    .launch_ack(launch_ack), .touched(touched), .draw_valid(draw_valid),
    .draw_ready(draw_ready), .draw_id(draw_id), .draw_kind(draw_kind),
    .draw_x(draw_x), .draw_prev_x(draw_prev_x), .wall_state(wall_state),
    .wall_x(wall_x), .any_stopped(any_stopped)
  );

  wall_fleet_ctrl #(.N_WALLS(1), .X_W(8), .X_START(3), .X_END(0), .STEP(2), .MOVE_DIV(1)) dut_s (
    .clk(clk), .resetn(resetn), .frame_tick(frame_s), .launch(launch_s),
    .launch_ack(launch_ack_s), .touched(touched_s), .draw_valid(draw_valid_s),
    .draw_ready(ready_s), .draw_id(draw_id_s), .draw_kind(draw_kind_s),
    .draw_x(draw_x_s), .draw_prev_x(draw_prev_x_s), .wall_state(wall_state_s),
    .wall_x(wall_x_s), .any_stopped(any_stopped_s)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    resetn = 1'b0; frame_tick = 1'b0; launch = 1'b0; draw_ready = 1'b0; touched = '0;
    frame_s = 1'b0; launch_s = 1'b0; ready_s = 1'b1; touched_s = '0;
    tick(); tick();
    check("rst_state", wall_state, 32'h5555);
    check("rst_x", wall_x, 32'h9f9f9f9f);
    check("rst_valid", draw_valid, 0);
    check("rst_ack", launch_ack, 0);
    check("rst_stopped", any_stopped, 0);
    resetn = 1'b1;

    // First launch with an idle drawer.
    draw_ready = 1'b1; launch = 1'b1;
    tick();
    launch = 1'b0;
    check("l1_ack", launch_ack, 1);
    check("l1_state", wall_state, 32'h5558);
    check("l1_valid", draw_valid, 1);
    check("l1_kind", draw_kind, 0);
    check("l1_x", draw_x, 159);
    check("l1_id", draw_id, 0);
    tick();
    check("l1_ack_pulse", launch_ack, 0);
    check("l1_move", wall_state, 32'h5556);
    check("l1_idle", draw_valid, 0);

    // Four frame ticks at MOVE_DIV=2 give two shifts.
    frame_tick = 1'b1; tick();
    frame_tick = 1'b0; tick();
    check("div_no_pulse", draw_valid, 0);
    frame_tick = 1'b1; tick();
    frame_tick = 1'b0;
    check("sh1_kind", draw_kind, 1);
    check("sh1_x", draw_x, 158);
    check("sh1_prev", draw_prev_x, 159);
    check("sh1_wall_x", wall_x, 32'h9f9f9f9e);
    tick();
    check("sh1_back", wall_state, 32'h5556);
    frame_tick = 1'b1; tick();
    frame_tick = 1'b0; tick();
    frame_tick = 1'b1; tick();
    frame_tick = 1'b0;
    check("sh2_x", draw_x, 157);
    check("sh2_prev", draw_prev_x, 158);
    tick();
    check("sh2_back", wall_state, 32'h5556);
    check("sh2_wall_x", wall_x, 32'h9f9f9f9d);

    // Reset while a job is outstanding.
    draw_ready = 1'b0; launch = 1'b1;
    tick();
    check("mid_id", draw_id, 1);
    check("mid_valid", draw_valid, 1);
    resetn = 1'b0; launch = 1'b0;
    tick();
    check("mid_rst_valid", draw_valid, 0);
    check("mid_rst_state", wall_state, 32'h5555);
    resetn = 1'b1;

    // Fill all four walls against a stalled drawer, then a fifth launch.
    launch = 1'b1;
    tick();
    check("fill0_state", wall_state, 32'h5558);
    tick(); tick(); tick();
    check("fill3_state", wall_state, 32'h8888);
    check("fill3_ack", launch_ack, 1);
    tick();
    launch = 1'b0;
    check("fifth_ack", launch_ack, 0);
    check("fifth_state", wall_state, 32'h8888);
    for (int c = 0; c < 3; c++) begin
      check("stall_id", draw_id, 0);
      check("stall_kind", draw_kind, 0);
      check("stall_x", draw_x, 159);
      tick();
    end
    draw_ready = 1'b1;
    tick();
    check("rr_id1", draw_id, 1);
    check("rr_state1", wall_state, 32'h8886);
    tick();
    check("rr_id2", draw_id, 2);
    tick();
    check("rr_id3", draw_id, 3);
    tick();
    check("rr_done_valid", draw_valid, 0);
    check("rr_done_state", wall_state, 32'h6666);

    // Touch on wall 1 coincident with a move pulse.
    frame_tick = 1'b1; tick();
    touched = 4'b0010; tick();
    frame_tick = 1'b0; touched = '0;
    check("tch_state", wall_state, 32'h8888);
    check("tch_a_id", draw_id, 0);
    check("tch_a_kind", draw_kind, 1);
    check("tch_wall_x", wall_x, 32'h9e9e9f9e);
    tick();
    check("tch_b_id", draw_id, 1);
    check("tch_b_kind", draw_kind, 2);
    check("tch_b_x", draw_x, 159);
    check("tch_b_prev", draw_prev_x, 159);
    check("tch_b_stopped", any_stopped, 0);
    tick();
    check("tch_c_state", wall_state, 32'h8876);
    check("tch_c_stopped", any_stopped, 1);
    tick();
    check("tch_d_state", wall_state, 32'h8656);
    check("tch_d_stopped", any_stopped, 0);
    tick();
    check("tch_e_state", wall_state, 32'h6656);
    check("tch_e_valid", draw_valid, 0);

    // Retired wall 1 is relaunchable.
    launch = 1'b1; tick();
    launch = 1'b0;
    check("re_ack", launch_ack, 1);
    check("re_id", draw_id, 1);
    check("re_kind", draw_kind, 0);
    tick();
    check("re_state", wall_state, 32'h6666);

    // Short track: 3 -> 1 -> end of track.
    launch_s = 1'b1; tick();
    launch_s = 1'b0;
    check("s_place_x", draw_x_s, 3);
    check("s_place_state", wall_state_s, 8);
    tick();
    frame_s = 1'b1; tick();
    frame_s = 1'b0;
    check("s_sh_kind", draw_kind_s, 1);
    check("s_sh_x", draw_x_s, 1);
    check("s_sh_prev", draw_prev_x_s, 3);
    tick();
    check("s_sh_back", wall_state_s, 6);
    frame_s = 1'b1; tick();
    frame_s = 1'b0;
`ifdef WALL_WRAP_EN
    check("s_end_kind", draw_kind_s, 1);
    check("s_end_x", draw_x_s, 3);
    check("s_end_prev", draw_prev_x_s, 1);
    check("s_end_wall_x", wall_x_s, 3);
    tick();
    check("s_end_state", wall_state_s, 6);
`else
    check("s_end_kind", draw_kind_s, 2);
    check("s_end_x", draw_x_s, 1);
    check("s_end_prev", draw_prev_x_s, 1);
    check("s_end_wall_x", wall_x_s, 1);
    tick();
    check("s_end_state", wall_state_s, 5);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
